exers: RTL and testbench
========================

EXERS -- requirements
Module: exers

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst  in  1  asynchronous, active-low reset (asserted at 0).
REQ-003 rename_exers_write  in  1  dispatch request from rename; taken only when exers_stall=0.
REQ-004 rename_op  in  5  reservation-station opcode.
REQ-005 rename_robid  in  7  ROB id of the dispatched instruction.
REQ-006 rename_rd  in  6  destination; bit5=1 means no architectural write.
REQ-007 rename_op1ready, rename_op2ready  in  1 each  operand holds a value (1) or a tag in bits[6:0] (0).
REQ-008 rename_op1, rename_op2  in  32 each  operand value or tag.
REQ-009 rename_imm  in  32  immediate, carried unchanged.
REQ-010 exers_stall  out  1  station full; rename holds its stage.
REQ-011 wb_valid  in  1  result broadcast valid.
REQ-012 wb_tag  in  7  ROB id of the broadcast result.
REQ-013 wb_value  in  32  broadcast result value.
REQ-014 exers_alu_valid  out  1  issue-register valid.
REQ-015 exers_alu_op/robid/rd/op1/op2/imm  out  5/7/6/32/32/32  issued instruction fields.
REQ-016 alu_stall  in  1  ALU cannot accept; the issue register holds.
REQ-017 rob_flush  in  1  synchronous flush of all speculative state.

Function
REQ-018 The station has 8 entries: valid, op, robid, rd, op1rdy, op1, op2rdy, op2, imm.
REQ-019 exers_stall = (valid-entry count == 8), decoded from registered state only; same-cycle issue does not clear it.
REQ-020 Accept: when rename_exers_write=1 and exers_stall=0, write the lowest-index free entry at the clock edge.
REQ-021 Wakeup: at each edge with wb_valid=1, every valid entry whose operand is not ready and whose tag equals wb_tag gets op=wb_value and rdy=1.
REQ-022 Bypass: an entry being accepted with a non-ready operand whose tag equals a same-cycle wb_tag is written ready with wb_value.
REQ-023 An entry is eligible when it is valid, op1rdy=1 and op2rdy=1 in registered state; an entry woken at edge N first becomes eligible in the cycle after edge N.
REQ-024 Select: the lowest-index eligible entry is chosen when the issue register is empty or (exers_alu_valid=1 and alu_stall=0).
REQ-025 Issue: at that edge the chosen entry moves into the issue register and its valid bit clears; with no eligible entry, exers_alu_valid clears.
REQ-026 When exers_alu_valid=1 and alu_stall=1, the issue register and all selection hold; entries still accept and wake up.
REQ-027 Minimum latency: an entry accepted ready at edge N gives exers_alu_valid=1 after edge N+1.
REQ-028 Accept and issue in the same edge are both performed; the freed and written slots may coincide only if the slot was free before that edge.
REQ-029 rob_flush=1: at the edge, all entries and exers_alu_valid clear; a same-cycle accept is dropped; flush overrides every other update.
REQ-030 Issued operand values are never modified by a later wb broadcast.

Reset
REQ-031 While rst=0, all entry valid bits and exers_alu_valid are 0 and exers_stall is 0; data fields are don't-care.
REQ-032 A reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

Structure
REQ-033 The shared package holds the constants RS_DEPTH=8, ROBID_W=7, OP_W=5 and RD_W=6, plus the entry struct typedef.
REQ-034 Lowest-index selection (free-slot and eligible-entry) is one sub-module, exers_pick, instantiated twice.

Verification
REQ-035 Dispatch op1rdy=1 op1=5, op2rdy=1 op2=7, robid=3 at edge 1 -> exers_alu_valid=1, robid=3, op1=5, op2=7 after edge 2.
REQ-036 Dispatch op1rdy=0 op1=0x0A, then wb_valid=1 wb_tag=0x0A wb_value=0xDEADBEEF -> issued op1=0xDEADBEEF one cycle after the wakeup edge.
REQ-037 Dispatch with tag 0x11 in the same cycle as wb_tag=0x11 wb_value=9 -> entry is stored ready and issues with op1=9.
REQ-038 Eight non-ready dispatches -> exers_stall=1; a ninth write is ignored; a wakeup then issue of one entry -> exers_stall=0 the cycle after issue.
REQ-039 exers_alu_valid=1 with alu_stall=1 for 3 cycles -> outputs stable; on release the next ready entry issues at the following edge.
REQ-040 Occupancy of 5 with rob_flush=1 and a concurrent write -> after the edge all entries invalid, exers_alu_valid=0, exers_stall=0.

Source files
------------

// File: rtl/exers_pkg.sv
// exers_pkg: shared constants, entry type and wakeup helper for the ALU reservation station
package exers_pkg;
  localparam int RS_DEPTH = 8;
  localparam int ROBID_W = 7;
  localparam int OP_W = 5;
  localparam int RD_W = 6;
  localparam int DATA_W = 32;
  localparam int IDX_W = $clog2(RS_DEPTH);
  typedef struct packed {
    logic valid;
    logic [OP_W-1:0] op;
    logic [ROBID_W-1:0] robid;
    logic [RD_W-1:0] rd;
    logic op1rdy;
    logic [DATA_W-1:0] op1;
    logic op2rdy;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] imm;
  } rs_entry_t;
  // A waiting operand keeps its producer tag in the low bits of the value field.
  function automatic logic tag_hit(input logic rdy, input logic [DATA_W-1:0] opv,
                                   input logic wbv, input logic [ROBID_W-1:0] tag);
    return wbv && !rdy && opv[ROBID_W-1:0] == tag;
  endfunction
endpackage

// File: rtl/exers_pick.sv
// exers_pick: lowest-index set-bit finder
//   req_i   request vector
//   found_o any bit set
//   idx_o   index of the lowest set bit (0 when none)
module exers_pick
  import exers_pkg::*;
#(
  parameter int N = RS_DEPTH
) (
  input  logic [N-1:0]         req_i,
  output logic                 found_o,
  output logic [$clog2(N)-1:0] idx_o
);
  always_comb begin
    found_o = |req_i;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) if (req_i[i]) idx_o = i[$clog2(N)-1:0];
  end
endmodule

// File: rtl/exers.sv
// exers: 8-entry ALU reservation station with wakeup, same-cycle bypass and in-order-by-index issue
//   clk, rst (async, active-low)
//   rename_*     dispatch request and instruction fields; exers_stall back-pressures rename
//   wb_*         result broadcast used to wake waiting operands
//   exers_alu_*  registered issue slot; alu_stall holds it
//   rob_flush    drops all entries and the issue slot
module exers
  import exers_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               rename_exers_write,
  input  logic [OP_W-1:0]    rename_op,
  input  logic [ROBID_W-1:0] rename_robid,
  input  logic [RD_W-1:0]    rename_rd,
  input  logic               rename_op1ready,
  input  logic               rename_op2ready,
  input  logic [DATA_W-1:0]  rename_op1,
  input  logic [DATA_W-1:0]  rename_op2,
  input  logic [DATA_W-1:0]  rename_imm,
  output logic               exers_stall,
  input  logic               wb_valid,
  input  logic [ROBID_W-1:0] wb_tag,
  input  logic [DATA_W-1:0]  wb_value,
  output logic               exers_alu_valid,
  output logic [OP_W-1:0]    exers_alu_op,
  output logic [ROBID_W-1:0] exers_alu_robid,
  output logic [RD_W-1:0]    exers_alu_rd,
  output logic [DATA_W-1:0]  exers_alu_op1,
  output logic [DATA_W-1:0]  exers_alu_op2,
  output logic [DATA_W-1:0]  exers_alu_imm,
  input  logic               alu_stall,
  input  logic               rob_flush
);
  rs_entry_t [RS_DEPTH-1:0] ent_q, ent_d;
  rs_entry_t new_ent;
  logic iss_vld_q, iss_vld_d;
  logic [OP_W-1:0] iss_op_q, iss_op_d;
  logic [ROBID_W-1:0] iss_rob_q, iss_rob_d;
  logic [RD_W-1:0] iss_rd_q, iss_rd_d;
  logic [DATA_W-1:0] iss_op1_q, iss_op1_d, iss_op2_q, iss_op2_d, iss_imm_q, iss_imm_d;
  logic [RS_DEPTH-1:0] vld, elig;
  logic free_found, elig_found, sel_en, accept, issue, byp1, byp2;
  logic [IDX_W-1:0] free_idx, sel_idx;
  always_comb
    for (int i = 0; i < RS_DEPTH; i++) begin
      vld[i] = ent_q[i].valid;
      elig[i] = ent_q[i].valid && ent_q[i].op1rdy && ent_q[i].op2rdy;
    end
  exers_pick #(.N(RS_DEPTH)) u_free (.req_i(~vld), .found_o(free_found), .idx_o(free_idx));
  exers_pick #(.N(RS_DEPTH)) u_sel (.req_i(elig), .found_o(elig_found), .idx_o(sel_idx));
  // Full is judged on registered occupancy only, so a slot freed by this edge's issue is not reusable yet.
  assign exers_stall = &vld;
  assign accept = rename_exers_write && free_found;
  assign sel_en = !iss_vld_q || !alu_stall;
  assign issue = sel_en && elig_found;
  assign byp1 = tag_hit(rename_op1ready, rename_op1, wb_valid, wb_tag);
  assign byp2 = tag_hit(rename_op2ready, rename_op2, wb_valid, wb_tag);
  always_comb begin
    new_ent = '{valid: 1'b1, op: rename_op, robid: rename_robid, rd: rename_rd,
                op1rdy: rename_op1ready || byp1, op1: byp1 ? wb_value : rename_op1,
                op2rdy: rename_op2ready || byp2, op2: byp2 ? wb_value : rename_op2,
                imm: rename_imm};
    ent_d = ent_q;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (ent_q[i].valid && tag_hit(ent_q[i].op1rdy, ent_q[i].op1, wb_valid, wb_tag)) begin
        ent_d[i].op1rdy = 1'b1;
        ent_d[i].op1 = wb_value;
      end
      if (ent_q[i].valid && tag_hit(ent_q[i].op2rdy, ent_q[i].op2, wb_valid, wb_tag)) begin
        ent_d[i].op2rdy = 1'b1;
        ent_d[i].op2 = wb_value;
      end
      if (issue && sel_idx == i[IDX_W-1:0]) ent_d[i].valid = 1'b0;
      if (accept && free_idx == i[IDX_W-1:0]) ent_d[i] = new_ent;
    end
  end
  always_comb begin
    iss_vld_d = sel_en ? elig_found : iss_vld_q;
    iss_op_d = sel_en ? ent_q[sel_idx].op : iss_op_q;
    iss_rob_d = sel_en ? ent_q[sel_idx].robid : iss_rob_q;
    iss_rd_d = sel_en ? ent_q[sel_idx].rd : iss_rd_q;
    iss_op1_d = sel_en ? ent_q[sel_idx].op1 : iss_op1_q;
    iss_op2_d = sel_en ? ent_q[sel_idx].op2 : iss_op2_q;
    iss_imm_d = sel_en ? ent_q[sel_idx].imm : iss_imm_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ent_q <= '0;
      iss_vld_q <= 1'b0;
    end else if (rob_flush) begin
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i].valid <= 1'b0;
      iss_vld_q <= 1'b0;
    end else begin
      ent_q <= ent_d;
      iss_vld_q <= iss_vld_d;
    end
  // Issue payload needs no reset; only its valid bit is architecturally visible.
  always_ff @(posedge clk) begin
    iss_op_q <= iss_op_d;
    iss_rob_q <= iss_rob_d;
    iss_rd_q <= iss_rd_d;
    iss_op1_q <= iss_op1_d;
    iss_op2_q <= iss_op2_d;
    iss_imm_q <= iss_imm_d;
  end
  assign exers_alu_valid = iss_vld_q;
  assign exers_alu_op = iss_op_q;
  assign exers_alu_robid = iss_rob_q;
  assign exers_alu_rd = iss_rd_q;
  assign exers_alu_op1 = iss_op1_q;
  assign exers_alu_op2 = iss_op2_q;
  assign exers_alu_imm = iss_imm_q;
endmodule

// File: tb/tb_exers.sv
// tb_exers: table-driven and scoreboard checks for the exers reservation station
module tb_exers;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rename_exers_write = 1'b0;
  logic [4:0] rename_op = '0;
  logic [6:0] rename_robid = '0;
  logic [5:0] rename_rd = '0;
  logic rename_op1ready = 1'b0, rename_op2ready = 1'b0;
  logic [31:0] rename_op1 = '0, rename_op2 = '0, rename_imm = '0;
  logic exers_stall;
  logic wb_valid = 1'b0;
  logic [6:0] wb_tag = '0;
  logic [31:0] wb_value = '0;
  logic exers_alu_valid;
  logic [4:0] exers_alu_op;
  logic [6:0] exers_alu_robid;
  logic [5:0] exers_alu_rd;
  logic [31:0] exers_alu_op1, exers_alu_op2, exers_alu_imm;
  logic alu_stall = 1'b0;
  logic rob_flush = 1'b0;

  exers dut (
    .clk(clk), .rst(rst),
    .rename_exers_write(rename_exers_write), .rename_op(rename_op), .rename_robid(rename_robid),
    .rename_rd(rename_rd), .rename_op1ready(rename_op1ready), .rename_op2ready(rename_op2ready),
    .rename_op1(rename_op1), .rename_op2(rename_op2), .rename_imm(rename_imm),
    .exers_stall(exers_stall),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .exers_alu_valid(exers_alu_valid), .exers_alu_op(exers_alu_op), .exers_alu_robid(exers_alu_robid),
    .exers_alu_rd(exers_alu_rd), .exers_alu_op1(exers_alu_op1), .exers_alu_op2(exers_alu_op2),
    .exers_alu_imm(exers_alu_imm),
    .alu_stall(alu_stall), .rob_flush(rob_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r1; logic [31:0] o1; logic r2; logic [31:0] o2;
    logic wv; logic [6:0] wt; logic [31:0] wd;
    logic [4:0] op; logic [6:0] rob; logic [5:0] rd; logic [31:0] imm;
    logic [31:0] e1; logic [31:0] e2;
  } vec_t;

  vec_t tv[6];
  logic [113:0] sb[$];
  int n_cmp = 0, n_bad = 0;
  logic pv = 1'b0, pst = 1'b0;

  function automatic logic [113:0] pk(input logic [4:0] op, input logic [6:0] rob, input logic [5:0] rd,
                                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    return {op, rob, rd, a, b, im};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic r1, input logic [31:0] o1, input logic r2, input logic [31:0] o2,
                      input logic [4:0] op, input logic [6:0] rob, input logic [5:0] rd, input logic [31:0] imm,
                      input logic wv, input logic [6:0] wt, input logic [31:0] wd);
    rename_exers_write = 1'b1;
    rename_op1ready = r1; rename_op1 = o1;
    rename_op2ready = r2; rename_op2 = o2;
    rename_op = op; rename_robid = rob; rename_rd = rd; rename_imm = imm;
    wb_valid = wv; wb_tag = wt; wb_value = wd;
    step();
    rename_exers_write = 1'b0;
    wb_valid = 1'b0;
  endtask

  task automatic wbc(input logic [6:0] t, input logic [31:0] v);
    wb_valid = 1'b1; wb_tag = t; wb_value = v;
    step();
    wb_valid = 1'b0;
  endtask

  // Each new value presented in the issue register is popped against the scoreboard.
  always @(negedge clk) begin
    if (rst && exers_alu_valid && (!pv || !pst)) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_issue: got robid %0h, expected no issue", exers_alu_robid);
      end else begin
        logic [113:0] e;
        logic [113:0] a;
        e = sb.pop_front();
        a = {exers_alu_op, exers_alu_robid, exers_alu_rd, exers_alu_op1, exers_alu_op2, exers_alu_imm};
        if (a !== e) begin
          n_bad++;
          $display("FAIL issue_pkt: got %0h, expected %0h", a, e);
        end
      end
    end
    pv = exers_alu_valid;
    pst = alu_stall;
  end

  initial begin
    tv[0] = '{1'b1, 32'h11111111, 1'b1, 32'h22222222, 1'b0, 7'h00, 32'h0, 5'h01, 7'h01, 6'h05, 32'hA5A5A5A5, 32'h11111111, 32'h22222222};
    tv[1] = '{1'b0, 32'h11, 1'b1, 32'h3, 1'b1, 7'h11, 32'h9, 5'h02, 7'h02, 6'h06, 32'h1, 32'h9, 32'h3};
    tv[2] = '{1'b1, 32'h11, 1'b0, 32'h45, 1'b1, 7'h45, 32'hCAFEF00D, 5'h03, 7'h03, 6'h07, 32'h2, 32'h11, 32'hCAFEF00D};
    tv[3] = '{1'b1, 32'h45, 1'b1, 32'h6, 1'b1, 7'h45, 32'hBAD, 5'h04, 7'h04, 6'h08, 32'h3, 32'h45, 32'h6};
    tv[4] = '{1'b0, 32'h7F, 1'b0, 32'hFFFFFF7F, 1'b1, 7'h7F, 32'h0, 5'h05, 7'h05, 6'h09, 32'h4, 32'h0, 32'h0};
    tv[5] = '{1'b1, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b0, 7'h00, 32'h0, 5'h1F, 7'h7F, 6'h20, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", exers_alu_valid, 0);
    chk("rst_stall", exers_stall, 0);
    rst = 1'b1;
    step();

    // Minimum latency: accept at edge 1, issue register valid after edge 2.
    sb.push_back(pk(5'h0, 7'h3, 6'h1, 32'd5, 32'd7, 32'h0));
    disp(1'b1, 32'd5, 1'b1, 32'd7, 5'h0, 7'h3, 6'h1, 32'h0, 1'b0, 7'h0, 32'h0);
    chk("lat_edge1", exers_alu_valid, 0);
    step();
    chk("lat_edge2", {exers_alu_valid, exers_alu_robid, exers_alu_op1, exers_alu_op2}, {1'b1, 7'h3, 32'd5, 32'd7});
    step();

    for (int i = 0; i < 6; i++) begin
      sb.push_back(pk(tv[i].op, tv[i].rob, tv[i].rd, tv[i].e1, tv[i].e2, tv[i].imm));
      disp(tv[i].r1, tv[i].o1, tv[i].r2, tv[i].o2, tv[i].op, tv[i].rob, tv[i].rd, tv[i].imm, tv[i].wv, tv[i].wt, tv[i].wd);
    end
    repeat (3) step();

    // Wakeup by a later broadcast.
    disp(1'b0, 32'h0A, 1'b1, 32'h1, 5'h1, 7'h20, 6'h2, 32'h0, 1'b0, 7'h0, 32'h0);
    repeat (2) step();
    chk("wait_no_issue", exers_alu_valid, 0);
    sb.push_back(pk(5'h1, 7'h20, 6'h2, 32'hDEADBEEF, 32'h1, 32'h0));
    wbc(7'h0A, 32'hDEADBEEF);
    chk("wake_edge", exers_alu_valid, 0);
    step();
    chk("wake_issue", {exers_alu_valid, exers_alu_op1}, {1'b1, 32'hDEADBEEF});
    step();

    // Fill all eight slots with waiting entries.
    for (int i = 0; i < 8; i++)
      disp(1'b0, 32'(i + 'h40), 1'b1, 32'(i), 5'h2, 7'(i + 'h50), 6'h3, 32'(i + 'h100), 1'b0, 7'h0, 32'h0);
    chk("full_stall", exers_stall, 1);
    disp(1'b1, 32'h1, 1'b1, 32'h1, 5'h7, 7'h7D, 6'h7, 32'h0, 1'b0, 7'h0, 32'h0);
    chk("ninth_stall", exers_stall, 1);
    step();
    chk("ninth_no_issue", exers_alu_valid, 0);
    sb.push_back(pk(5'h2, 7'h53, 6'h3, 32'h1234, 32'd3, 32'h103));
    wbc(7'h43, 32'h1234);
    chk("stall_after_wake", exers_stall, 1);
    step();
    chk("stall_after_issue", {exers_stall, exers_alu_valid, exers_alu_robid}, {1'b0, 1'b1, 7'h53});

    // Issue-register hold under alu_stall.
    sb.push_back(pk(5'h2, 7'h50, 6'h3, 32'hAAAA0000, 32'd0, 32'h100));
    sb.push_back(pk(5'h2, 7'h51, 6'h3, 32'hBBBB0001, 32'd1, 32'h101));
    wbc(7'h40, 32'hAAAA0000);
    wbc(7'h41, 32'hBBBB0001);
    alu_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("hold", {exers_alu_valid, exers_alu_robid, exers_alu_op1}, {1'b1, 7'h50, 32'hAAAA0000});
      step();
    end
    alu_stall = 1'b0;
    chk("hold_release", {exers_alu_valid, exers_alu_robid, exers_alu_op1}, {1'b1, 7'h50, 32'hAAAA0000});
    step();
    chk("after_release", {exers_alu_valid, exers_alu_robid, exers_alu_op1}, {1'b1, 7'h51, 32'hBBBB0001});
    step();
    chk("drained_issue", exers_alu_valid, 0);

    // Flush with five occupied slots and a concurrent write.
    rob_flush = 1'b1;
    disp(1'b1, 32'h1, 1'b1, 32'h2, 5'h3, 7'h7E, 6'h4, 32'h0, 1'b0, 7'h0, 32'h0);
    rob_flush = 1'b0;
    chk("flush_state", {exers_stall, exers_alu_valid}, {1'b0, 1'b0});
    wbc(7'h42, 32'h55);
    chk("flush_drop_write", exers_alu_valid, 0);
    step();
    chk("flush_cleared", exers_alu_valid, 0);

    // Asynchronous reset between clock edges.
    for (int i = 0; i < 8; i++)
      disp(1'b0, 32'(i + 'h60), 1'b1, 32'(i), 5'h4, 7'(i + 'h10), 6'h5, 32'h0, 1'b0, 7'h0, 32'h0);
    chk("refill_stall", exers_stall, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst", {exers_stall, exers_alu_valid}, {1'b0, 1'b0});
    step();
    rst = 1'b1;
    step();
    wbc(7'h60, 32'h5);
    step();
    chk("rst_cleared", exers_alu_valid, 0);
    sb.push_back(pk(5'h6, 7'h33, 6'h21, 32'h77, 32'h88, 32'h99));
    disp(1'b1, 32'h77, 1'b1, 32'h88, 5'h6, 7'h33, 6'h21, 32'h99, 1'b0, 7'h0, 32'h0);

    for (int k = 0; k < 20 && sb.size() > 0; k++) step();
    step();
    chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
